// File: rtl/pc_fetch_unit.sv
// PC and instruction-register stage feeding the multicycle control FSM.
// Holds the PC, runs the two-cycle fetch handshake and applies PC-update strobes.
module pc_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  nextInstruction,
  input  logic                  PCEN,
  input  logic                  BranchEN,
  input  logic                  JmpEN,
  input  logic                  JALEN,
  input  logic [7:0]            branchDisp,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  input  logic [15:0]           memData,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           instruction,
  output logic [3:0]            opCode1,
  output logic [3:0]            conditionCode,
  output logic [3:0]            opCode2,
  output logic [3:0]            shiftAmt,
  output logic [ADDR_WIDTH-1:0] fetchPC,
  output logic [ADDR_WIDTH-1:0] linkAddr,
  output logic                  instrValid,
  output logic                  fetchError
);

  typedef enum logic [0:0] {StIdle, StAddr} fetch_state_e;

  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [15:0]           r_instr;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_link;
  logic                  r_valid;
  logic                  r_error;

  logic [ADDR_WIDTH-1:0] w_disp_ext;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic [ADDR_WIDTH-1:0] w_pc_branch;

  // pc already points past the current instruction, so the branch is relative to it.
  assign w_disp_ext  = {{(ADDR_WIDTH-8){branchDisp[7]}}, branchDisp};
  assign w_pc_inc    = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_pc_branch = r_pc + w_disp_ext;

  // Fetch handshake: first strobe cycle presents the address, second captures the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_instr    <= 16'h0000;
      r_fetch_pc <= RESET_PC;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (nextInstruction) begin
            r_state    <= StAddr;
            r_fetch_pc <= r_pc;
            r_valid    <= 1'b0;
          end
        end
        StAddr: begin
          r_state <= StIdle;
          if (nextInstruction) begin
            r_instr <= memData;
            r_valid <= 1'b1;
          end else begin
            r_error <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_link <= '0;
    end else if (PCEN) begin
      if (JALEN) begin
        r_link <= r_pc;
        r_pc   <= jumpTarget;
      end else if (JmpEN) begin
        r_pc <= jumpTarget;
      end else if (BranchEN) begin
        r_pc <= w_pc_branch;
      end else begin
        r_pc <= w_pc_inc;
      end
    end
  end

  assign pc            = r_pc;
  assign instruction   = r_instr;
  assign opCode1       = r_instr[15:12];
  assign conditionCode = r_instr[11:8];
  assign opCode2       = r_instr[7:4];
  assign shiftAmt      = r_instr[3:0];
  assign fetchPC       = r_fetch_pc;
  assign linkAddr      = r_link;
  assign instrValid    = r_valid;
  assign fetchError    = r_error;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed test-plan cases plus random stimulus against
// an arithmetic reference model of the PC and the fetch handshake.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        nextInstruction;
  logic        PCEN;
  logic        BranchEN;
  logic        JmpEN;
  logic        JALEN;
  logic [7:0]  branchDisp;
  logic [15:0] jumpTarget;
  logic [15:0] memData;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [3:0]  opCode1;
  logic [3:0]  conditionCode;
  logic [3:0]  opCode2;
  logic [3:0]  shiftAmt;
  logic [15:0] fetchPC;
  logic [15:0] linkAddr;
  logic        instrValid;
  logic        fetchError;

  pc_fetch_unit #(
    .ADDR_WIDTH(16),
    .RESET_PC  (16'h0000)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .nextInstruction(nextInstruction),
    .PCEN           (PCEN),
    .BranchEN       (BranchEN),
    .JmpEN          (JmpEN),
    .JALEN          (JALEN),
    .branchDisp     (branchDisp),
    .jumpTarget     (jumpTarget),
    .memData        (memData),
    .pc             (pc),
    .instruction    (instruction),
    .opCode1        (opCode1),
    .conditionCode  (conditionCode),
    .opCode2        (opCode2),
    .shiftAmt       (shiftAmt),
    .fetchPC        (fetchPC),
    .linkAddr       (linkAddr),
    .instrValid     (instrValid),
    .fetchError     (fetchError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_pc;
  int          m_link;
  int          m_fpc;
  logic [15:0] m_ir;
  bit          m_valid;
  bit          m_err;
  int          m_strobes;  // consecutive strobe cycles seen in the current fetch

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_link = 0; m_fpc = 0; m_ir = 16'h0000;
    m_valid = 0; m_err = 0; m_strobes = 0;
  endtask

  task automatic check_all();
    check("pc", 32'(pc), 32'(m_pc));
    check("instruction", 32'(instruction), 32'(m_ir));
    check("opCode1", 32'(opCode1), 32'(m_ir >> 12));
    check("conditionCode", 32'(conditionCode), 32'((m_ir >> 8) & 16'hF));
    check("opCode2", 32'(opCode2), 32'((m_ir >> 4) & 16'hF));
    check("shiftAmt", 32'(shiftAmt), 32'(m_ir & 16'hF));
    check("fetchPC", 32'(fetchPC), 32'(m_fpc));
    check("linkAddr", 32'(linkAddr), 32'(m_link));
    check("instrValid", 32'(instrValid), 32'(m_valid));
    check("fetchError", 32'(fetchError), 32'(m_err));
  endtask

  // Advance one clock with the currently driven inputs; model is updated from pre-edge values.
  task automatic cycle();
    int disp;
    if (nextInstruction) begin
      if (m_strobes == 0) begin
        m_fpc = m_pc; m_valid = 0; m_strobes = 1;
      end else begin
        m_ir = memData; m_valid = 1; m_strobes = 0;
      end
    end else if (m_strobes != 0) begin
      m_err = 1; m_strobes = 0;
    end
    if (PCEN) begin
      if (JALEN) begin
        m_link = m_pc; m_pc = int'(jumpTarget);
      end else if (JmpEN) begin
        m_pc = int'(jumpTarget);
      end else if (BranchEN) begin
        disp = (branchDisp >= 8'd128) ? int'(branchDisp) - 256 : int'(branchDisp);
        m_pc = ((m_pc + disp) % 65536 + 65536) % 65536;
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit nx, input bit en, input bit br, input bit jmp, input bit jal,
                       input logic [7:0] d, input logic [15:0] jt, input logic [15:0] md);
    nextInstruction = nx; PCEN = en; BranchEN = br; JmpEN = jmp; JALEN = jal;
    branchDisp = d; jumpTarget = jt; memData = md;
  endtask

  task automatic idle_inputs();
    drive(0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000);
  endtask

  task automatic jump_to(input logic [15:0] t);
    drive(0, 1, 0, 1, 0, 8'h00, t, 16'h0000);
    cycle();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    #1 check_all();
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_all();

    // Two-cycle fetch: FETCH increments pc, FETCH2 captures memData
    drive(1, 1, 0, 0, 0, 8'h00, 16'h0000, 16'hDEAD);
    cycle();
    check("addr_phase_valid", 32'(instrValid), 32'd0);
    drive(1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h5123);
    cycle();
    check("fetch_pc", 32'(pc), 32'h0001);
    check("fetch_fpc", 32'(fetchPC), 32'h0000);
    check("fetch_op1", 32'(opCode1), 32'h5);
    check("fetch_cc", 32'(conditionCode), 32'h1);
    check("fetch_op2", 32'(opCode2), 32'h2);
    check("fetch_sh", 32'(shiftAmt), 32'h3);
    check("fetch_valid", 32'(instrValid), 32'd1);

    // Branches, relative to the already-incremented pc
    jump_to(16'h0010);
    drive(0, 1, 1, 0, 0, 8'hFC, 16'h0000, 16'h0000);
    cycle();
    check("br_neg", 32'(pc), 32'h000C);
    jump_to(16'h0010);
    drive(0, 1, 1, 0, 0, 8'h05, 16'h0000, 16'h0000);
    cycle();
    check("br_pos", 32'(pc), 32'h0015);
    drive(0, 0, 1, 1, 1, 8'h05, 16'h1234, 16'h0000);
    cycle();
    check("pcen_low_hold", 32'(pc), 32'h0015);

    // JAL then plain jump
    jump_to(16'h0021);
    drive(0, 1, 0, 0, 1, 8'h00, 16'h0400, 16'h0000);
    cycle();
    check("jal_pc", 32'(pc), 32'h0400);
    check("jal_link", 32'(linkAddr), 32'h0021);
    drive(0, 1, 0, 1, 0, 8'h00, 16'h0100, 16'h0000);
    cycle();
    check("jmp_pc", 32'(pc), 32'h0100);
    check("jmp_link_kept", 32'(linkAddr), 32'h0021);
    drive(0, 1, 1, 1, 1, 8'h7F, 16'h0777, 16'h0000);
    cycle();
    check("jal_over_jmp", 32'(linkAddr), 32'h0100);

    // Wrap-around
    jump_to(16'hFFFF);
    drive(1, 1, 0, 0, 0, 8'h00, 16'h0000, 16'h0000);
    cycle();
    check("wrap_inc", 32'(pc), 32'h0000);
    check("wrap_fpc", 32'(fetchPC), 32'hFFFF);
    drive(1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h9ABC);
    cycle();
    jump_to(16'hFFFF);
    drive(0, 1, 1, 0, 0, 8'h02, 16'h0000, 16'h0000);
    cycle();
    check("wrap_br", 32'(pc), 32'h0001);

    // Aborted fetch: single-cycle strobe
    drive(1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h1111);
    cycle();
    drive(0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h2222);
    cycle();
    check("abort_err", 32'(fetchError), 32'd1);
    check("abort_ir", 32'(instruction), 32'h9ABC);
    idle_inputs();
    repeat (3) cycle();
    check("abort_sticky", 32'(fetchError), 32'd1);

    // Random stimulus; fetch strobes usually come in pairs
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            8'($urandom), 16'($urandom), 16'($urandom));
      if (m_strobes != 0 && $urandom_range(0, 7) != 0) nextInstruction = 1'b1;
      cycle();
    end

    // Async reset in the address cycle, no clock edge needed
    idle_inputs();
    jump_to(16'h0033);
    drive(1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'hABCD);
    cycle();
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_pc", 32'(pc), 32'h0000);
    check("async_ir", 32'(instruction), 32'h0000);
    check("async_valid", 32'(instrValid), 32'd0);
    check_all();
    @(posedge clk);
    #1 check_all();
    #2 reset = 1'b1;
    idle_inputs();
    cycle();
    check("post_reset_err", 32'(fetchError), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
